// File: rtl/sensor_frame_ctrl_pkg.sv
// sensor_pkg: shared state encoding, geometry defaults and width helper for the frame controller
package sensor_pkg;
  typedef enum logic [2:0] {IDLE, ERASE, EXPOSE, CONVERT, ROW_SEL, STREAM, DONE} state_t;
  localparam int DEF_WIDTH  = 4;
  localparam int DEF_HEIGHT = 4;
  localparam int DEF_BITS   = 8;
  function automatic int clog2(input int v);
    int r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/sensor_frame_ctrl_if.sv
// sensor_frame_ctrl_if: valid/ready pixel stream with frame and line markers
interface sensor_frame_ctrl_if #(parameter int PIXEL_BITS = 8) ();
  logic                  pix_valid;
  logic                  pix_ready;
  logic [PIXEL_BITS-1:0] pix_data;
  logic                  pix_sof;
  logic                  pix_eol;
  logic                  pix_eof;
  modport master (output pix_valid, pix_data, pix_sof, pix_eol, pix_eof, input pix_ready);
  modport slave  (input pix_valid, pix_data, pix_sof, pix_eol, pix_eof, output pix_ready);
endinterface

// File: rtl/sensor_frame_ctrl_row_serializer.sv
// row_serializer: latches one row of pixels and plays it out over valid/ready with markers
module row_serializer
  import sensor_pkg::*;
#(
  parameter int W = DEF_WIDTH,
  parameter int B = DEF_BITS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_first_row,
  input  logic         i_last_row,
  input  logic [W*B-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [B-1:0] o_data,
  output logic         o_sof,
  output logic         o_eol,
  output logic         o_eof,
  output logic         o_row_done
);
  localparam int CLW = clog2(W);
  logic [W*B-1:0] r_buf;
  logic [CLW-1:0] r_col;
  logic           r_last_row;
  logic           w_fire;
  logic [CLW-1:0] w_next;
  logic           w_next_eol;
  assign w_fire     = o_valid & i_ready;
  assign w_next     = r_col + CLW'(1);
  assign w_next_eol = (w_next == CLW'(W - 1));
  assign o_row_done = w_fire & o_eol;
  // load a row, then advance one column per accepted pixel; outputs hold while stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_buf      <= '0;
      r_col      <= '0;
      r_last_row <= 1'b0;
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_sof      <= 1'b0;
      o_eol      <= 1'b0;
      o_eof      <= 1'b0;
    end else if (i_load) begin
      r_buf      <= i_data;
      r_col      <= '0;
      r_last_row <= i_last_row;
      o_valid    <= 1'b1;
      o_data     <= i_data[B-1:0];
      o_sof      <= i_first_row;
      o_eol      <= (W == 1);
      o_eof      <= (W == 1) && i_last_row;
    end else if (w_fire) begin
      if (o_eol) begin
        o_valid <= 1'b0;
        o_data  <= '0;
        o_sof   <= 1'b0;
        o_eol   <= 1'b0;
        o_eof   <= 1'b0;
      end else begin
        r_col  <= w_next;
        o_data <= r_buf[int'(w_next)*B +: B];
        o_sof  <= 1'b0;
        o_eol  <= w_next_eol;
        o_eof  <= w_next_eol && r_last_row;
      end
    end
  end
endmodule

// File: rtl/sensor_frame_ctrl.sv
// sensor_frame_ctrl: erase/expose/convert/readout sequencer feeding a pixel stream
module sensor_frame_ctrl
  import sensor_pkg::*;
#(
  parameter int PIXEL_ARRAY_WIDTH  = DEF_WIDTH,
  parameter int PIXEL_ARRAY_HEIGHT = DEF_HEIGHT,
  parameter int PIXEL_BITS         = DEF_BITS,
  parameter int ERASE_CYCLES       = 5,
  parameter int EXP_BITS           = 8
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic                                    continuous,
  input  logic [EXP_BITS-1:0]                     exposure_cycles,
  output logic                                    p_erase,
  output logic                                    p_expose,
  output logic                                    p_expose_clk,
  output logic [PIXEL_ARRAY_HEIGHT-1:0]           p_row_select,
  output logic                                    p_aRamp,
  output logic [PIXEL_BITS-1:0]                   p_dRamp,
  input  logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0] p_data_in,
  sensor_frame_ctrl_if.master                     pix,
  output logic                                    busy,
  output logic                                    frame_done
);
  localparam int H  = PIXEL_ARRAY_HEIGHT;
  localparam int EW = clog2(ERASE_CYCLES + 1);
  localparam int CW = (EW > EXP_BITS) ? EW : EXP_BITS;
  localparam int RW = clog2(H);
  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [EXP_BITS-1:0] r_exp;
  logic [RW-1:0]       r_row;
  logic [EXP_BITS-1:0] w_exp_in;
  logic                w_last_row;
  logic                w_row_done;
  assign w_exp_in   = (exposure_cycles == '0) ? EXP_BITS'(1) : exposure_cycles;
  assign w_last_row = (r_row == RW'(H - 1));
  row_serializer #(.W(PIXEL_ARRAY_WIDTH), .B(PIXEL_BITS)) u_ser (
    .clk        (clk),
    .reset      (reset),
    .i_load     (r_state == ROW_SEL),
    .i_first_row(r_row == '0),
    .i_last_row (w_last_row),
    .i_data     (p_data_in),
    .i_ready    (pix.pix_ready),
    .o_valid    (pix.pix_valid),
    .o_data     (pix.pix_data),
    .o_sof      (pix.pix_sof),
    .o_eol      (pix.pix_eol),
    .o_eof      (pix.pix_eof),
    .o_row_done (w_row_done)
  );
  // frame sequencer; every array-facing output is set on the edge that enters its state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_exp        <= '0;
      r_row        <= '0;
      p_erase      <= 1'b0;
      p_expose     <= 1'b0;
      p_expose_clk <= 1'b0;
      p_row_select <= '0;
      p_aRamp      <= 1'b0;
      p_dRamp      <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_state <= ERASE;
          r_exp   <= w_exp_in;
          r_cnt   <= '0;
          p_erase <= 1'b1;
          busy    <= 1'b1;
        end
        ERASE: if (r_cnt == CW'(ERASE_CYCLES - 1)) begin
          r_state      <= EXPOSE;
          r_cnt        <= '0;
          p_erase      <= 1'b0;
          p_expose     <= 1'b1;
          p_expose_clk <= 1'b1;
        end else r_cnt <= r_cnt + CW'(1);
        EXPOSE: if (r_cnt + CW'(1) == CW'(r_exp)) begin
          r_state      <= CONVERT;
          p_expose     <= 1'b0;
          p_expose_clk <= 1'b0;
          p_aRamp      <= 1'b1;
          p_dRamp      <= '0;
        end else begin
          r_cnt        <= r_cnt + CW'(1);
          p_expose_clk <= ~p_expose_clk;
        end
        CONVERT: if (&p_dRamp) begin
          r_state      <= ROW_SEL;
          p_aRamp      <= 1'b0;
          p_dRamp      <= '0;
          r_row        <= '0;
          p_row_select <= H'(1);
        end else p_dRamp <= p_dRamp + PIXEL_BITS'(1);
        ROW_SEL: begin
          r_state      <= STREAM;
          p_row_select <= '0;
        end
        STREAM: if (w_row_done) begin
          if (w_last_row) begin
            r_state    <= DONE;
            frame_done <= 1'b1;
          end else begin
            r_state      <= ROW_SEL;
            r_row        <= r_row + RW'(1);
            p_row_select <= H'(1) << (r_row + RW'(1));
          end
        end
        DONE: if (continuous) begin
          r_state <= ERASE;
          r_cnt   <= '0;
          p_erase <= 1'b1;
          if (start) r_exp <= w_exp_in;
        end else begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sensor_frame_ctrl.sv
// tb_sensor_frame_ctrl: directed checks of sequencing, readout order, backpressure and reset
module tb_sensor_frame_ctrl;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, continuous = 1'b0;
  logic [7:0] exp_c = 8'd10;
  logic p_erase, p_expose, p_expose_clk, p_aRamp, busy, frame_done;
  logic [3:0] row_sel;
  logic [7:0] dramp;
  logic [31:0] pdata;
  logic start2 = 1'b0;
  logic e_erase, e_expose, e_expose_clk, e_aRamp, e_busy, e_done;
  logic [0:0] e_row_sel;
  logic [1:0] e_dramp, pdata2;
  int n_cmp = 0, n_bad = 0;
  int e_cnt, x_cnt, a_cnt, max_ramp, ramp_bad, clk_bad, done_cyc, e_first, stable_bad, flag_bad;
  logic [7:0] pix_q[$];
  logic [3:0] rs_q[$];
  bit sof_q[$], eol_q[$], eof_q[$];

  sensor_frame_ctrl_if #(.PIXEL_BITS(8)) pif ();
  sensor_frame_ctrl_if #(.PIXEL_BITS(2)) pif2 ();

  always #5 clk = ~clk;

  // array model: row r drives 8'h10*r+c on column c while selected, 8'hEE otherwise
  always_comb begin
    pdata = {4{8'hEE}};
    for (int r = 0; r < 4; r++)
      if (row_sel[r]) for (int c = 0; c < 4; c++) pdata[c*8 +: 8] = 8'(16*r + c);
  end
  assign pdata2 = e_row_sel[0] ? 2'b10 : 2'b01;

  sensor_frame_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous), .exposure_cycles(exp_c),
    .p_erase(p_erase), .p_expose(p_expose), .p_expose_clk(p_expose_clk), .p_row_select(row_sel),
    .p_aRamp(p_aRamp), .p_dRamp(dramp), .p_data_in(pdata), .pix(pif.master),
    .busy(busy), .frame_done(frame_done)
  );

  sensor_frame_ctrl #(.PIXEL_ARRAY_WIDTH(1), .PIXEL_ARRAY_HEIGHT(1), .PIXEL_BITS(2), .ERASE_CYCLES(2), .EXP_BITS(8)) dut_e (
    .clk(clk), .reset(reset), .start(start2), .continuous(1'b0), .exposure_cycles(8'd0),
    .p_erase(e_erase), .p_expose(e_expose), .p_expose_clk(e_expose_clk), .p_row_select(e_row_sel),
    .p_aRamp(e_aRamp), .p_dRamp(e_dramp), .p_data_in(pdata2), .pix(pif2.master),
    .busy(e_busy), .frame_done(e_done)
  );

  // observes one frame of the main DUT from a negedge; records, does not judge
  task automatic capture(input bit do_start, input bit rnd, input int stop_pix, input int noise_at, input int drop_at);
    int cyc = 0;
    bit pv = 0, pr = 0, xprev = 0, done = 0;
    logic [10:0] prev = '0;
    e_cnt = 0; x_cnt = 0; a_cnt = 0; max_ramp = 0; ramp_bad = 0; clk_bad = 0;
    done_cyc = 0; e_first = 0; stable_bad = 0; flag_bad = 0;
    pix_q.delete(); rs_q.delete(); sof_q.delete(); eol_q.delete(); eof_q.delete();
    if (do_start) start = 1'b1;
    while (!done && cyc < 2000 && (stop_pix == 0 || pix_q.size() < stop_pix)) begin
      @(negedge clk);
      cyc++;
      start = (noise_at != 0) && (cyc >= noise_at) && (cyc < noise_at + 3);
      if (noise_at != 0 && cyc == noise_at) exp_c = 8'd3;
      if (drop_at != 0 && cyc == drop_at) continuous = 1'b0;
      if (p_erase) begin e_cnt++; if (e_first == 0) e_first = cyc; end
      if (p_expose) begin
        x_cnt++;
        if (x_cnt == 1 ? !p_expose_clk : (p_expose_clk == xprev)) clk_bad++;
        xprev = p_expose_clk;
      end else if (p_expose_clk) clk_bad++;
      if (p_aRamp) begin
        if (dramp != 8'(a_cnt)) ramp_bad++;
        a_cnt++; max_ramp = int'(dramp);
      end else if (dramp != 0) ramp_bad++;
      if (row_sel != 0) rs_q.push_back(row_sel);
      if (!pif.pix_valid && (pif.pix_sof | pif.pix_eol | pif.pix_eof)) flag_bad++;
      if (pv && !pr && (!pif.pix_valid || {pif.pix_data, pif.pix_sof, pif.pix_eol, pif.pix_eof} != prev)) stable_bad++;
      pif.pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      pv = pif.pix_valid; pr = pif.pix_ready;
      prev = {pif.pix_data, pif.pix_sof, pif.pix_eol, pif.pix_eof};
      if (pv && pr) begin
        pix_q.push_back(pif.pix_data); sof_q.push_back(pif.pix_sof);
        eol_q.push_back(pif.pix_eol); eof_q.push_back(pif.pix_eof);
      end
      if (frame_done) begin done = 1; done_cyc = cyc; end
    end
  endtask

  task automatic test_reset;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({busy, frame_done, p_erase, p_expose, p_expose_clk, p_aRamp, dramp, row_sel, pif.pix_valid, pif.pix_data, pif.pix_sof, pif.pix_eol, pif.pix_eof} !== '0) begin n_bad++; $display("FAIL reset_main outputs not all zero (busy=%b valid=%b)", busy, pif.pix_valid); end
    n_cmp++; if ({e_busy, e_done, e_erase, e_expose, e_aRamp, e_row_sel, pif2.pix_valid} !== '0) begin n_bad++; $display("FAIL reset_edge outputs not all zero (busy=%b)", e_busy); end
    reset = 1'b1;
    pif.pix_ready = 1'b1; pif2.pix_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_single;
    exp_c = 8'd10;
    capture(1, 0, 0, 0, 0);
    n_cmp++; if (e_cnt !== 5) begin n_bad++; $display("FAIL erase_cycles got %0d want 5", e_cnt); end
    n_cmp++; if (x_cnt !== 10) begin n_bad++; $display("FAIL expose_cycles got %0d want 10", x_cnt); end
    n_cmp++; if (clk_bad !== 0) begin n_bad++; $display("FAIL expose_clk_pattern errors got %0d want 0", clk_bad); end
    n_cmp++; if (a_cnt !== 256) begin n_bad++; $display("FAIL aramp_cycles got %0d want 256", a_cnt); end
    n_cmp++; if (max_ramp !== 255 || ramp_bad !== 0) begin n_bad++; $display("FAIL dramp last=%0d errors=%0d want 255/0", max_ramp, ramp_bad); end
    n_cmp++; if (done_cyc !== 292) begin n_bad++; $display("FAIL frame_done_cycle got %0d want 292", done_cyc); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_in_done got %b want 1", busy); end
    n_cmp++; if (rs_q.size() !== 4) begin n_bad++; $display("FAIL row_select_count got %0d want 4", rs_q.size()); end
    for (int i = 0; i < rs_q.size() && i < 4; i++) begin
      n_cmp++; if (rs_q[i] !== 4'(1 << i)) begin n_bad++; $display("FAIL row_select[%0d] got %b want %b", i, rs_q[i], 4'(1 << i)); end
    end
    n_cmp++; if (pix_q.size() !== 16) begin n_bad++; $display("FAIL pixel_count got %0d want 16", pix_q.size()); end
    for (int i = 0; i < pix_q.size() && i < 16; i++) begin
      n_cmp++; if (pix_q[i] !== 8'(16*(i/4) + i%4) || sof_q[i] !== (i == 0) || eol_q[i] !== (i%4 == 3) || eof_q[i] !== (i == 15)) begin
        n_bad++; $display("FAIL pixel[%0d] got %h sof/eol/eof %b%b%b want %h %b%b%b", i, pix_q[i], sof_q[i], eol_q[i], eof_q[i], 8'(16*(i/4) + i%4), i == 0, i%4 == 3, i == 15);
      end
    end
    n_cmp++; if (flag_bad !== 0) begin n_bad++; $display("FAIL markers_without_valid got %0d want 0", flag_bad); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || frame_done !== 1'b0) begin n_bad++; $display("FAIL after_done busy=%b frame_done=%b want 0/0", busy, frame_done); end
  endtask

  task automatic test_backpressure;
    exp_c = 8'd10;
    capture(1, 1, 0, 0, 0);
    pif.pix_ready = 1'b1;
    n_cmp++; if (stable_bad !== 0) begin n_bad++; $display("FAIL stall_stability errors got %0d want 0", stable_bad); end
    n_cmp++; if (done_cyc < 292) begin n_bad++; $display("FAIL bp_frame_done_cycle got %0d want >=292", done_cyc); end
    n_cmp++; if (pix_q.size() !== 16) begin n_bad++; $display("FAIL bp_pixel_count got %0d want 16", pix_q.size()); end
    for (int i = 0; i < pix_q.size() && i < 16; i++) begin
      n_cmp++; if (pix_q[i] !== 8'(16*(i/4) + i%4) || sof_q[i] !== (i == 0) || eol_q[i] !== (i%4 == 3) || eof_q[i] !== (i == 15)) begin
        n_bad++; $display("FAIL bp_pixel[%0d] got %h sof/eol/eof %b%b%b want %h", i, pix_q[i], sof_q[i], eol_q[i], eof_q[i], 8'(16*(i/4) + i%4));
      end
    end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bp_busy_after got %b want 0", busy); end
  endtask

  task automatic test_continuous;
    exp_c = 8'd10; continuous = 1'b1;
    capture(1, 0, 0, 50, 0);
    n_cmp++; if (done_cyc !== 292) begin n_bad++; $display("FAIL cont_frame1_done got %0d want 292", done_cyc); end
    n_cmp++; if (x_cnt !== 10) begin n_bad++; $display("FAIL cont_frame1_expose got %0d want 10", x_cnt); end
    capture(0, 0, 0, 0, 100);
    n_cmp++; if (e_first !== 1 || e_cnt !== 5) begin n_bad++; $display("FAIL cont_rearm first_erase=%0d erase=%0d want 1/5", e_first, e_cnt); end
    n_cmp++; if (x_cnt !== 10) begin n_bad++; $display("FAIL cont_reused_exposure got %0d want 10", x_cnt); end
    n_cmp++; if (done_cyc !== 292 || pix_q.size() !== 16) begin n_bad++; $display("FAIL cont_frame2 done=%0d pixels=%0d want 292/16", done_cyc, pix_q.size()); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || p_erase !== 1'b0) begin n_bad++; $display("FAIL cont_to_idle busy=%b erase=%b want 0/0", busy, p_erase); end
    exp_c = 8'd10;
  endtask

  task automatic test_reset_mid;
    exp_c = 8'd10;
    capture(1, 0, 6, 0, 0);
    n_cmp++; if (pif.pix_valid !== 1'b1 || pix_q.size() !== 6) begin n_bad++; $display("FAIL mid_stream valid=%b pixels=%0d want 1/6", pif.pix_valid, pix_q.size()); end
    #1 reset = 1'b0;
    #1;
    n_cmp++; if ({busy, frame_done, p_erase, p_expose, p_expose_clk, p_aRamp, dramp, row_sel, pif.pix_valid, pif.pix_data, pif.pix_sof, pif.pix_eol, pif.pix_eof} !== '0) begin n_bad++; $display("FAIL async_reset outputs not zero (busy=%b valid=%b data=%h)", busy, pif.pix_valid, pif.pix_data); end
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || pif.pix_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset busy=%b valid=%b want 0/0", busy, pif.pix_valid); end
    capture(1, 0, 0, 0, 0);
    n_cmp++; if (pix_q.size() !== 16 || done_cyc !== 292) begin n_bad++; $display("FAIL fresh_frame pixels=%0d done=%0d want 16/292", pix_q.size(), done_cyc); end
    n_cmp++; if (pix_q.size() == 0 || pix_q[0] !== 8'h00 || sof_q[0] !== 1'b1) begin n_bad++; $display("FAIL fresh_sof first pixel/sof wrong want 00/1"); end
    @(negedge clk);
  endtask

  task automatic test_exp_zero;
    exp_c = 8'd0;
    capture(1, 0, 0, 0, 0);
    n_cmp++; if (x_cnt !== 1) begin n_bad++; $display("FAIL exp0_expose got %0d want 1", x_cnt); end
    n_cmp++; if (done_cyc !== 283) begin n_bad++; $display("FAIL exp0_done_cycle got %0d want 283", done_cyc); end
    @(negedge clk);
    exp_c = 8'd10;
  endtask

  task automatic test_edge;
    int cyc = 0, nv = 0, nx = 0, dc = 0;
    logic [1:0] d = '0;
    logic [2:0] f = '0;
    start2 = 1'b1;
    while (dc == 0 && cyc < 200) begin
      @(negedge clk);
      cyc++; start2 = 1'b0;
      if (e_expose) nx++;
      if (pif2.pix_valid) begin nv++; d = pif2.pix_data; f = {pif2.pix_sof, pif2.pix_eol, pif2.pix_eof}; end
      if (e_done) dc = cyc;
    end
    n_cmp++; if (nv !== 1 || d !== 2'b10) begin n_bad++; $display("FAIL edge_pixel count=%0d data=%b want 1/10", nv, d); end
    n_cmp++; if (f !== 3'b111) begin n_bad++; $display("FAIL edge_markers got %b want 111", f); end
    n_cmp++; if (nx !== 1) begin n_bad++; $display("FAIL edge_expose got %0d want 1", nx); end
    n_cmp++; if (dc !== 10) begin n_bad++; $display("FAIL edge_done_cycle got %0d want 10", dc); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_backpressure;
    test_continuous;
    test_reset_mid;
    test_exp_zero;
    test_edge;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
